// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode constants for the 5-stage CPU.
// Holds opcode/funct encodings, the ALU operation enum and a
// sign-extension helper used by the decode stage.
package cpu_pkg;

  // Primary opcodes decoded by the ID stage (everything else is a NOP)
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGT   = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  // R-type funct field values
  localparam logic [5:0] FN_MUL = 6'd24;
  localparam logic [5:0] FN_DIV = 6'd26;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;

  // ALU operation carried in the D/X register
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_MUL = 4'd3,
    ALU_DIV = 4'd4
  } alu_op_e;

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: register file owned by the decode stage.
// Two combinational read ports, one write port, r0 hardwired to zero,
// same-cycle write-to-read bypass, asynchronous clear on rst.
module id_regfile
  import cpu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_r [NREG];

  // Storage: cleared on reset, written on the clock edge; r0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (we && (wa != 5'd0) && (32'(wa) < NREG)) begin
      regs_r[wa] <= wd;
    end else begin
      regs_r[0] <= 32'd0;
    end
  end

  // Read port 1: zero register, then writeback bypass, then storage
  always_comb begin
    rd1 = 32'd0;
    if ((ra1 == 5'd0) || (32'(ra1) >= NREG)) begin
      rd1 = 32'd0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_r[ra1];
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    rd2 = 32'd0;
    if ((ra2 == 5'd0) || (32'(ra2) >= NREG)) begin
      rd2 = 32'd0;
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_r[ra2];
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage of the 5-stage CPU.
// Decodes FD_IR, reads the register file, raises the jump request to
// fetch and loads the D/X pipeline register. Wrong-path instructions
// (bnoWB/jnoWB) become bubbles. Optional RAW hazard stall is built in
// when the macro ID_HAZARD_STALL_EN is defined; otherwise en is tied 1.
module instruction_decode
  import cpu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] FD_IR,
  input  logic [31:0] FD_PC,
  input  logic        bnoWB,
  input  logic        jnoWB,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [4:0]  XM_rd,
  input  logic        XM_regwrite,
  output logic        jump,
  output logic [27:0] address,
  output logic        en,
  output logic [31:0] DX_PC,
  output logic [31:0] DX_A,
  output logic [31:0] DX_B,
  output logic [31:0] offset,
  output logic [31:0] DX_imm,
  output logic [4:0]  DX_rd,
  output logic        DX_regwrite,
  output logic [3:0]  DX_alu_op,
  output logic        DX_alusrc,
  output logic        beq,
  output logic        bne,
  output logic        bgt
);

  logic [5:0]  opcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [5:0]  funct_s;
  logic [31:0] imm_ext_s;
  logic        kill_s;
  logic        stall_s;
  logic        bubble_s;
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;

  logic        dec_rw_s;
  logic [4:0]  dec_rd_s;
  alu_op_e     dec_op_s;
  logic        dec_src_s;
  logic        dec_beq_s;
  logic        dec_bne_s;
  logic        dec_bgt_s;
  logic        dec_j_s;
  logic        use_rs_s;
  logic        use_rt_s;
  logic [31:0] dec_a_s;
  logic [31:0] dec_b_s;

  assign opcode_s  = FD_IR[31:26];
  assign rs_s      = FD_IR[25:21];
  assign rt_s      = FD_IR[20:16];
  assign rd_s      = FD_IR[15:11];
  assign funct_s   = FD_IR[5:0];
  assign imm_ext_s = sext16(FD_IR[15:0]);
  assign kill_s    = bnoWB | jnoWB;
  assign bubble_s  = kill_s | stall_s;

  id_regfile #(.NREG(NREG)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs_s),
    .ra2 (rt_s),
    .rd1 (rs_val_s),
    .rd2 (rt_val_s),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // Opcode decode; a killed instruction decodes as a NOP
  always_comb begin
    dec_rw_s  = 1'b0;
    dec_rd_s  = 5'd0;
    dec_op_s  = ALU_NOP;
    dec_src_s = 1'b0;
    dec_beq_s = 1'b0;
    dec_bne_s = 1'b0;
    dec_bgt_s = 1'b0;
    dec_j_s   = 1'b0;
    use_rs_s  = 1'b0;
    use_rt_s  = 1'b0;
    dec_a_s   = rs_val_s;
    dec_b_s   = rt_val_s;
    if (!kill_s) begin
      case (opcode_s)
        OP_RTYPE: begin
          case (funct_s)
            FN_MUL:  dec_op_s = ALU_MUL;
            FN_DIV:  dec_op_s = ALU_DIV;
            FN_ADD:  dec_op_s = ALU_ADD;
            FN_SUB:  dec_op_s = ALU_SUB;
            default: dec_op_s = ALU_NOP;
          endcase
          if (dec_op_s != ALU_NOP) begin
            dec_rw_s = 1'b1;
            dec_rd_s = rd_s;
            use_rs_s = 1'b1;
            use_rt_s = 1'b1;
          end else begin
            dec_rw_s = 1'b0;
          end
        end
        OP_J: begin
          dec_j_s = 1'b1;
        end
        OP_BEQ: begin
          dec_op_s  = ALU_SUB;
          dec_beq_s = 1'b1;
          use_rs_s  = 1'b1;
          use_rt_s  = 1'b1;
        end
        OP_BNE: begin
          dec_op_s  = ALU_SUB;
          dec_bne_s = 1'b1;
          use_rs_s  = 1'b1;
          use_rt_s  = 1'b1;
        end
        OP_BGT: begin
          // Swapped operands: rt - rs is negative exactly when rs > rt
          dec_op_s  = ALU_SUB;
          dec_bgt_s = 1'b1;
          use_rs_s  = 1'b1;
          use_rt_s  = 1'b1;
          dec_a_s   = rt_val_s;
          dec_b_s   = rs_val_s;
        end
        OP_ADDI: begin
          dec_op_s  = ALU_ADD;
          dec_src_s = 1'b1;
          dec_rw_s  = 1'b1;
          dec_rd_s  = rt_s;
          use_rs_s  = 1'b1;
        end
        default: begin
          dec_op_s = ALU_NOP;
        end
      endcase
    end else begin
      dec_op_s = ALU_NOP;
    end
  end

`ifdef ID_HAZARD_STALL_EN
  // RAW scoreboard: a used, non-zero source pending in D/X or X/M stalls
  always_comb begin
    stall_s = 1'b0;
    if (!kill_s &&
        ((use_rs_s && (rs_s != 5'd0) &&
          (((rs_s == DX_rd) && DX_regwrite) || ((rs_s == XM_rd) && XM_regwrite))) ||
         (use_rt_s && (rt_s != 5'd0) &&
          (((rt_s == DX_rd) && DX_regwrite) || ((rt_s == XM_rd) && XM_regwrite))))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end
`else
  logic unused_xm_s;
  assign unused_xm_s = ^{XM_rd, XM_regwrite};
  assign stall_s     = 1'b0;
`endif

  assign jump    = (opcode_s == OP_J) & dec_j_s & ~kill_s & ~stall_s;
  assign address = {FD_IR[25:0], 2'b00};
  assign en      = ~stall_s;

  // D/X pipeline register: bubble on squash or stall, else load decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DX_PC       <= 32'd0;
      DX_A        <= 32'd0;
      DX_B        <= 32'd0;
      offset      <= 32'd0;
      DX_imm      <= 32'd0;
      DX_rd       <= 5'd0;
      DX_regwrite <= 1'b0;
      DX_alu_op   <= ALU_NOP;
      DX_alusrc   <= 1'b0;
      beq         <= 1'b0;
      bne         <= 1'b0;
      bgt         <= 1'b0;
    end else if (bubble_s) begin
      DX_PC       <= 32'd0;
      DX_A        <= 32'd0;
      DX_B        <= 32'd0;
      offset      <= 32'd0;
      DX_imm      <= 32'd0;
      DX_rd       <= 5'd0;
      DX_regwrite <= 1'b0;
      DX_alu_op   <= ALU_NOP;
      DX_alusrc   <= 1'b0;
      beq         <= 1'b0;
      bne         <= 1'b0;
      bgt         <= 1'b0;
    end else begin
      DX_PC       <= FD_PC;
      DX_A        <= dec_a_s;
      DX_B        <= dec_b_s;
      offset      <= {imm_ext_s[29:0], 2'b00};
      DX_imm      <= imm_ext_s;
      DX_rd       <= dec_rd_s;
      DX_regwrite <= dec_rw_s;
      DX_alu_op   <= dec_op_s;
      DX_alusrc   <= dec_src_s;
      beq         <= dec_beq_s;
      bne         <= dec_bne_s;
      bgt         <= dec_bgt_s;
    end
  end

endmodule
